// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Display-side master for the touchscreen slot interface. Sweeps
//   display_number over slots 1..NUM_SLOTS. For each slot it waits for the
//   client's registered response and captures valid/name/value. It then
//   forwards the slot as one record to the LCD renderer over a valid/ready
//   handshake. Sweeps repeat, separated by an idle gap, while scan_en is high.
//
//   Optional build macro: SCAN_SKIP_BLANK_EN
//     defined     - slots that report display_valid=0 produce no record
//     not defined - every slot produces a record; blank slots carry rec_blank=1
//
// Ports
//   clk             in   1   system clock
//   reset           in   1   asynchronous, active-high reset
//   scan_en         in   1   1 = run sweeps; 0 = stop at the next slot boundary
//   display_number  out  6   slot currently addressed (1..NUM_SLOTS)
//   display_valid   in   1   client response: slot in use
//   display_name    in   40  client response: 5 ASCII chars, MSB = first char
//   display_value   in   32  client response: value
//   rec_valid       out  1   record available
//   rec_ready       in   1   renderer accepts record
//   rec_slot        out  6   slot number of record
//   rec_name        out  40  captured name
//   rec_value       out  32  captured value
//   rec_blank       out  1   1 = slot reported display_valid=0
//   sweep_done      out  1   one-cycle pulse after the last slot is handed off
module display_scan_ctrl #(
  parameter int unsigned NUM_SLOTS   = 44,
  parameter int unsigned SETTLE      = 1,
  parameter int unsigned REFRESH_GAP = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_en,
  output logic [5:0]  display_number,
  input  logic        display_valid,
  input  logic [39:0] display_name,
  input  logic [31:0] display_value,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [5:0]  rec_slot,
  output logic [39:0] rec_name,
  output logic [31:0] rec_value,
  output logic        rec_blank,
  output logic        sweep_done
);

  localparam int unsigned SETTLE_W = ($clog2(SETTLE + 1) < 1) ? 1 : $clog2(SETTLE + 1);
  localparam int unsigned GAP_W    = ($clog2(REFRESH_GAP + 1) < 1) ? 1 : $clog2(REFRESH_GAP + 1);

  localparam logic [5:0]          LAST_SLOT  = 6'(NUM_SLOTS);
  localparam logic [SETTLE_W-1:0] SETTLE_END = SETTLE_W'(SETTLE - 1);
  localparam logic [GAP_W-1:0]    GAP_END    = GAP_W'(REFRESH_GAP);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    CAPTURE,
    SEND,
    GAP
  } state_t;

  state_t              state, state_d;
  logic [5:0]          number_d;
  logic                valid_d;
  logic [5:0]          slot_d;
  logic [39:0]         name_d;
  logic [31:0]         value_d;
  logic                blank_d;
  logic                done_d;
  logic [SETTLE_W-1:0] settle_cnt, settle_d;
  logic [GAP_W-1:0]    gap_cnt, gap_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      display_number <= 6'd1;
      rec_valid      <= 1'b0;
      rec_slot       <= '0;
      rec_name       <= '0;
      rec_value      <= '0;
      rec_blank      <= 1'b0;
      sweep_done     <= 1'b0;
      settle_cnt     <= '0;
      gap_cnt        <= '0;
    end else begin
      state          <= state_d;
      display_number <= number_d;
      rec_valid      <= valid_d;
      rec_slot       <= slot_d;
      rec_name       <= name_d;
      rec_value      <= value_d;
      rec_blank      <= blank_d;
      sweep_done     <= done_d;
      settle_cnt     <= settle_d;
      gap_cnt        <= gap_d;
    end
  end

  always_comb begin
    state_d  = state;
    number_d = display_number;
    valid_d  = rec_valid;
    slot_d   = rec_slot;
    name_d   = rec_name;
    value_d  = rec_value;
    blank_d  = rec_blank;
    done_d   = 1'b0;
    settle_d = settle_cnt;
    gap_d    = gap_cnt;

    case (state)
      // display_number is held here: 1 after reset or a completed sweep,
      // or the next slot when scan_en dropped mid-sweep.
      IDLE: begin
        if (scan_en) begin
          state_d  = WAIT;
          settle_d = '0;
        end
      end

      WAIT: begin
        if (settle_cnt == SETTLE_END) begin
          state_d = CAPTURE;
        end else begin
          settle_d = settle_cnt + 1'b1;
        end
      end

      CAPTURE: begin
        state_d = SEND;
`ifdef SCAN_SKIP_BLANK_EN
        // A blank slot leaves rec_valid low; SEND then advances immediately.
        if (display_valid) begin
          valid_d = 1'b1;
          slot_d  = display_number;
          name_d  = display_name;
          value_d = display_value;
          blank_d = 1'b0;
        end
`else
        valid_d = 1'b1;
        slot_d  = display_number;
        blank_d = ~display_valid;
        name_d  = display_valid ? display_name  : '0;
        value_d = display_valid ? display_value : '0;
`endif
      end

      // rec_valid doubles as the "handshake pending" flag. The edge that
      // completes the handshake only drops rec_valid. The following edge
      // advances the slot, so consecutive records are never back-to-back.
      SEND: begin
        if (rec_valid) begin
          if (rec_ready) begin
            valid_d = 1'b0;
          end
        end else begin
          settle_d = '0;
          if (display_number == LAST_SLOT) begin
            number_d = 6'd1;
            done_d   = 1'b1;
            gap_d    = '0;
            state_d  = GAP;
          end else begin
            number_d = display_number + 6'd1;
            state_d  = scan_en ? WAIT : IDLE;
          end
        end
      end

      GAP: begin
        if (gap_cnt == GAP_END) begin
          settle_d = '0;
          state_d  = scan_en ? WAIT : IDLE;
        end else begin
          gap_d = gap_cnt + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl
//   Directed bench for display_scan_ctrl (NUM_SLOTS=44, SETTLE=1,
//   REFRESH_GAP=5). A registered client model answers display_number from
//   a slot table. The same table also holds the expected record fields.
//   The bench builds with or without SCAN_SKIP_BLANK_EN.
module tb_display_scan_ctrl;

  localparam int unsigned NSLOT = 44;
  localparam int unsigned STL   = 1;
  localparam int unsigned GAPC  = 5;

`ifdef SCAN_SKIP_BLANK_EN
  localparam logic SKIP = 1'b1;
  localparam logic [5:0] RST_SLOT = 6'd5;
  localparam int unsigned PERIOD = NSLOT * (STL + 2) + 3 + GAPC + 1;
`else
  localparam logic SKIP = 1'b0;
  localparam logic [5:0] RST_SLOT = 6'd30;
  localparam int unsigned PERIOD = NSLOT * (STL + 3) + GAPC + 1;
`endif

  typedef struct {
    logic        in_valid;
    logic [39:0] in_name;
    logic [31:0] in_value;
    logic        exp_blank;
    logic [39:0] exp_name;
    logic [31:0] exp_value;
  } vec_t;

  vec_t tbl [NSLOT];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        scan_en = 1'b0;
  logic [5:0]  display_number;
  logic        cv = 1'b0;
  logic [39:0] cname = '0;
  logic [31:0] cval = '0;
  logic        rec_valid;
  logic        rec_ready = 1'b0;
  logic [5:0]  rec_slot;
  logic [39:0] rec_name;
  logic [31:0] rec_value;
  logic        rec_blank;
  logic        sweep_done;

  logic        dyn = 1'b0;
  logic [31:0] cyc = '0;

  int n_vec = 0;
  int n_err = 0;

  display_scan_ctrl #(
    .NUM_SLOTS(NSLOT),
    .SETTLE(STL),
    .REFRESH_GAP(GAPC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .scan_en(scan_en),
    .display_number(display_number),
    .display_valid(cv),
    .display_name(cname),
    .display_value(cval),
    .rec_valid(rec_valid),
    .rec_ready(rec_ready),
    .rec_slot(rec_slot),
    .rec_name(rec_name),
    .rec_value(rec_value),
    .rec_blank(rec_blank),
    .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  // Registered client: responds one edge after display_number changes.
  // In dyn mode slot 6 reports a value that changes every cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (display_number >= 6'd1 && display_number <= 6'(NSLOT)) begin
      cv    <= tbl[display_number - 6'd1].in_valid;
      cname <= tbl[display_number - 6'd1].in_name;
      cval  <= (dyn && display_number == 6'd6) ? cyc : tbl[display_number - 6'd1].in_value;
    end else begin
      cv    <= 1'b0;
      cname <= '0;
      cval  <= '0;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_number"}, 64'(display_number), 64'd1);
    check({tag, "_valid"},  64'(rec_valid), 64'd0);
    check({tag, "_slot"},   64'(rec_slot), 64'd0);
    check({tag, "_name"},   64'(rec_name), 64'd0);
    check({tag, "_value"},  64'(rec_value), 64'd0);
    check({tag, "_blank"},  64'(rec_blank), 64'd0);
    check({tag, "_done"},   64'(sweep_done), 64'd0);
  endtask

  // Returns at the first falling edge showing rec_valid=1.
  task automatic get_rec(output logic [5:0] s, output logic b,
                         output logic [39:0] n, output logic [31:0] v);
    int unsigned k;
    k = 0;
    @(negedge clk);
    while (!rec_valid && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("rec_timeout", 64'(rec_valid), 64'd1);
    s = rec_slot;
    b = rec_blank;
    n = rec_name;
    v = rec_value;
  endtask

  task automatic wait_num(input logic [5:0] num);
    int unsigned k;
    k = 0;
    @(negedge clk);
    while (display_number != num && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("num_timeout", 64'(display_number), 64'(num));
  endtask

  task automatic wait_sweep(output logic [31:0] t);
    int unsigned k;
    k = 0;
    @(negedge clk);
    while (!sweep_done && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("sweep_timeout", 64'(sweep_done), 64'd1);
    t = cyc;
  endtask

  initial begin
    logic [5:0]  s;
    logic        b;
    logic [39:0] n;
    logic [31:0] v;
    logic [31:0] t1, t2, c;
    logic        found;

    for (int i = 0; i < int'(NSLOT); i++) begin
      tbl[i] = '{1'b0, "JUNK_", 32'hDEAD_0000 | 32'(i + 1), 1'b1, 40'h0, 32'h0};
    end
    tbl[3] = '{1'b1, "ADD_1", 32'h1, 1'b0, "ADD_1", 32'h1};
    tbl[4] = '{1'b1, "ADD_2", 32'h2, 1'b0, "ADD_2", 32'h2};
    tbl[5] = '{1'b1, "RESUL", 32'h3, 1'b0, "RESUL", 32'h3};

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset     = 1'b0;
    scan_en   = 1'b1;
    rec_ready = 1'b1;

    // Sweep 1: records in slot order, checked against the table
    for (int i = 0; i < int'(NSLOT); i++) begin
`ifdef SCAN_SKIP_BLANK_EN
      if (tbl[i].in_valid) begin
`else
      begin
`endif
        get_rec(s, b, n, v);
        check($sformatf("sw_slot%0d", i + 1), 64'(s), 64'(i + 1));
        check($sformatf("sw_blank%0d", i + 1), 64'(b), 64'(tbl[i].exp_blank & ~SKIP));
        check($sformatf("sw_name%0d", i + 1), 64'(n), 64'(tbl[i].exp_name));
        check($sformatf("sw_value%0d", i + 1), 64'(v), 64'(tbl[i].exp_value));
      end
    end

    // sweep_done pulse width, wrap to slot 1 and sweep period
    wait_sweep(t1);
    check("done_wrap_num", 64'(display_number), 64'd1);
    @(negedge clk);
    check("done_one_cycle", 64'(sweep_done), 64'd0);
    wait_sweep(t2);
    check("sweep_period", 64'(t2 - t1), 64'(PERIOD));

    // Stall slot 5 for 20 cycles with rec_ready low
    wait_num(6'd5);
    rec_ready = 1'b0;
    get_rec(s, b, n, v);
    check("stall_slot", 64'(s), 64'd5);
    check("stall_value", 64'(v), 64'd2);
    for (int i = 0; i < 20; i++) begin
      check("stall_valid", 64'(rec_valid), 64'd1);
      check("stall_hold_slot", 64'(rec_slot), 64'd5);
      check("stall_hold_name", 64'(rec_name), 64'("ADD_2"));
      check("stall_hold_value", 64'(rec_value), 64'd2);
      check("stall_hold_blank", 64'(rec_blank), 64'd0);
      check("stall_number", 64'(display_number), 64'd5);
      if (i < 19) @(negedge clk);
    end
    rec_ready = 1'b1;
    @(negedge clk);
    check("accept_valid_drop", 64'(rec_valid), 64'd0);
    check("accept_num_held", 64'(display_number), 64'd5);
    @(negedge clk);
    check("accept_num_next", 64'(display_number), 64'd6);

    // Slot 6 value changes every cycle: sample must be the one registered
    // by the client on the first edge after the number change.
    dyn = 1'b1;
    c   = cyc;
    get_rec(s, b, n, v);
    dyn = 1'b0;
    check("dyn_slot", 64'(s), 64'd6);
    check("dyn_value", 64'(v), 64'(c));
    check("dyn_name", 64'(n), 64'("RESUL"));

    // scan_en dropped during WAIT of slot 10
    wait_num(6'd10);
    scan_en = 1'b0;
`ifndef SCAN_SKIP_BLANK_EN
    get_rec(s, b, n, v);
    check("stop_slot", 64'(s), 64'd10);
    check("stop_blank", 64'(b), 64'd1);
`endif
    repeat (10) @(negedge clk);
    check("stop_num", 64'(display_number), 64'd11);
    check("stop_no_rec", 64'(rec_valid), 64'd0);
    scan_en = 1'b1;
    get_rec(s, b, n, v);
`ifdef SCAN_SKIP_BLANK_EN
    check("resume_slot", 64'(s), 64'd4);
`else
    check("resume_slot", 64'(s), 64'd11);
`endif

    // Asynchronous reset mid-cycle while a record is valid
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      get_rec(s, b, n, v);
      if (s == RST_SLOT) found = 1'b1;
    end
    check("rst_slot_found", 64'(found), 64'd1);
    #2 reset = 1'b1;
    #1 check_reset_vals("async_rst");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    get_rec(s, b, n, v);
`ifdef SCAN_SKIP_BLANK_EN
    check("post_rst_slot", 64'(s), 64'd4);
`else
    check("post_rst_slot", 64'(s), 64'd1);
    check("post_rst_blank", 64'(b), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
